// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the fetch stage: word type, opcodes, PC step and fetch FSM states.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [5:0] {
        RTYPE = 6'b000000,
        J     = 6'b000010,
        JAL   = 6'b000011,
        BEQ   = 6'b000100,
        BNE   = 6'b000101,
        ADDI  = 6'b001000,
        LW    = 6'b100011,
        SW    = 6'b101011,
        HALT  = 6'b111111
    } opcode_t;

    localparam word_t PC_STEP = 32'd4;

    typedef enum logic {
        RUN       = 1'b0,
        HALT_SEEN = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/pipereg_if.sv
// IF/ID pipeline register bundle; the fetch stage drives it and decode reads it.
interface pipereg_if_id;
    cpu_types_pkg::word_t instr;
    cpu_types_pkg::word_t pc;
    cpu_types_pkg::word_t pcn;
    logic                 valid;

    modport stage  (output instr, pc, pcn, valid);
    modport decode (input  instr, pc, pcn, valid);
endinterface

// File: rtl/if_fetch_stage_pc_reg.sv
// Program counter register: a redirect target beats sequential advance, otherwise hold.
module pc_reg
    import cpu_types_pkg::*;
#(
    parameter logic [31:0] PC_INIT = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        advance,
    output logic [31:0] pc
);

    word_t next_pc;

    // The increment wraps naturally at 2^32 because of the 32-bit width.
    always_comb begin
        next_pc = pc;
        if (redirect)
            next_pc = redirect_pc;
        else if (advance)
            next_pc = pc + PC_STEP;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pc <= PC_INIT;
        else
            pc <= next_pc;
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage with the IF/ID latch and HALT-stop FSM.
// Optional FETCH_PERF_EN adds fetch and stall counters.
module if_fetch_stage
    import cpu_types_pkg::*;
#(
    parameter logic [31:0] PC_INIT = 32'h00000000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        WEN,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic [31:0] pcn_out,
    output logic        valid_out,
    output logic        halted_out
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt
`endif
);

    fetch_state_t state, next_state;
    word_t        pc;
    logic         load;
    logic         is_halt;

    pipereg_if_id ifid ();

    assign is_halt = (opcode_t'(imemload[31:26]) == HALT);
    assign load    = !redirect && WEN && (state == RUN) && ihit;

    pc_reg #(.PC_INIT(PC_INIT)) u_pc_reg (
        .clk        (CLK),
        .rst_n      (nRST),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .advance    (load),
        .pc         (pc)
    );

    assign imemREN  = (state == RUN);
    assign imemaddr = pc;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            state <= RUN;
        else
            state <= next_state;
    end

    // A redirect squashes a pending halt, including one arriving in the same cycle.
    always_comb begin
        next_state = state;
        if (redirect)
            next_state = RUN;
        else if (load && is_halt)
            next_state = HALT_SEEN;
    end

    // Stalls hold the latch; every other non-loading cycle inserts a bubble.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ifid.instr <= '0;
            ifid.pc    <= '0;
            ifid.pcn   <= '0;
            ifid.valid <= 1'b0;
        end else if (load) begin
            ifid.instr <= imemload;
            ifid.pc    <= pc;
            ifid.pcn   <= pc + PC_STEP;
            ifid.valid <= 1'b1;
        end else if (redirect || WEN) begin
            ifid.instr <= '0;
            ifid.pc    <= '0;
            ifid.pcn   <= '0;
            ifid.valid <= 1'b0;
        end
    end

    assign instr_out  = ifid.instr;
    assign pc_out     = ifid.pc;
    assign pcn_out    = ifid.pcn;
    assign valid_out  = ifid.valid;
    assign halted_out = (state == HALT_SEEN);

`ifdef FETCH_PERF_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (load)
                fetch_cnt <= fetch_cnt + 32'd1;
            if (!redirect && (state == RUN) && (!WEN || !ihit))
                stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed table-driven bench for if_fetch_stage, plus hand sequences for reset and PC wrap.
module tb_if_fetch_stage;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit;
    logic [31:0] imemload;
    logic        WEN;
    logic        redirect;
    logic [31:0] redirect_pc;

    logic        imemREN, imemREN2;
    logic [31:0] imemaddr, imemaddr2;
    logic [31:0] instr_out, instr_out2;
    logic [31:0] pc_out, pc_out2;
    logic [31:0] pcn_out, pcn_out2;
    logic        valid_out, valid_out2;
    logic        halted_out, halted_out2;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt, stall_cnt, fetch_cnt2, stall_cnt2;
`endif

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    if_fetch_stage dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload),
        .imemREN(imemREN), .imemaddr(imemaddr), .WEN(WEN),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .instr_out(instr_out), .pc_out(pc_out), .pcn_out(pcn_out),
        .valid_out(valid_out), .halted_out(halted_out)
`ifdef FETCH_PERF_EN
        , .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
`endif
    );

    // Second instance starts at the last word so the PC+4 wrap can be observed.
    if_fetch_stage #(.PC_INIT(32'hFFFFFFFC)) dut_wrap (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload),
        .imemREN(imemREN2), .imemaddr(imemaddr2), .WEN(WEN),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .instr_out(instr_out2), .pc_out(pc_out2), .pcn_out(pcn_out2),
        .valid_out(valid_out2), .halted_out(halted_out2)
`ifdef FETCH_PERF_EN
        , .fetch_cnt(fetch_cnt2), .stall_cnt(stall_cnt2)
`endif
    );

    typedef struct {
        string       name;
        logic        ihit;
        logic        wen;
        logic        redir;
        logic [31:0] rpc;
        logic [31:0] load;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pcn;
        logic        valid;
        logic        halted;
        logic        ren;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic hit, logic wen, logic redir,
                                logic [31:0] rpc, logic [31:0] load, logic [31:0] addr,
                                logic [31:0] instr, logic [31:0] pc, logic [31:0] pcn,
                                logic valid, logic halted, logic ren);
        vec_t v;
        v.name = name; v.ihit = hit; v.wen = wen; v.redir = redir; v.rpc = rpc;
        v.load = load; v.addr = addr; v.instr = instr; v.pc = pc; v.pcn = pcn;
        v.valid = valid; v.halted = halted; v.ren = ren;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        ihit        = v.ihit;
        WEN         = v.wen;
        redirect    = v.redir;
        redirect_pc = v.rpc;
        imemload    = v.load;
        @(posedge CLK);
        #1;
    endtask

    localparam logic [31:0] ADDI_W = 32'h20010005;
    localparam logic [31:0] LW_W   = 32'h8C220000;
    localparam logic [31:0] ADD_W  = 32'h00221820;
    localparam logic [31:0] HALT_W = 32'hFC000000;

    initial begin
        //              name          hit wen rd rpc        load    addr      instr   pc        pcn       v  h  ren
        vecs.push_back(mk("fetch0",    1, 1, 0, 32'h0,  ADDI_W, 32'h04, ADDI_W, 32'h00, 32'h04, 1, 0, 1));
        vecs.push_back(mk("fetch4",    1, 1, 0, 32'h0,  ADDI_W, 32'h08, ADDI_W, 32'h04, 32'h08, 1, 0, 1));
        vecs.push_back(mk("miss1",     0, 1, 0, 32'h0,  ADDI_W, 32'h08, 32'h0,  32'h00, 32'h00, 0, 0, 1));
        vecs.push_back(mk("miss2",     0, 1, 0, 32'h0,  ADDI_W, 32'h08, 32'h0,  32'h00, 32'h00, 0, 0, 1));
        vecs.push_back(mk("miss3",     0, 1, 0, 32'h0,  ADDI_W, 32'h08, 32'h0,  32'h00, 32'h00, 0, 0, 1));
        vecs.push_back(mk("fetch8",    1, 1, 0, 32'h0,  LW_W,   32'h0C, LW_W,   32'h08, 32'h0C, 1, 0, 1));
        vecs.push_back(mk("stall1",    1, 0, 0, 32'h0,  ADD_W,  32'h0C, LW_W,   32'h08, 32'h0C, 1, 0, 1));
        vecs.push_back(mk("stall2",    1, 0, 0, 32'h0,  ADD_W,  32'h0C, LW_W,   32'h08, 32'h0C, 1, 0, 1));
        vecs.push_back(mk("fetchC",    1, 1, 0, 32'h0,  ADD_W,  32'h10, ADD_W,  32'h0C, 32'h10, 1, 0, 1));
        vecs.push_back(mk("redir40",   1, 0, 1, 32'h40, ADDI_W, 32'h40, 32'h0,  32'h00, 32'h00, 0, 0, 1));
        vecs.push_back(mk("fetch40",   1, 1, 0, 32'h0,  ADDI_W, 32'h44, ADDI_W, 32'h40, 32'h44, 1, 0, 1));
        vecs.push_back(mk("redirHalt", 1, 1, 1, 32'h20, HALT_W, 32'h20, 32'h0,  32'h00, 32'h00, 0, 0, 1));
        vecs.push_back(mk("halt20",    1, 1, 0, 32'h0,  HALT_W, 32'h24, HALT_W, 32'h20, 32'h24, 1, 1, 0));
        vecs.push_back(mk("haltHold1", 1, 1, 0, 32'h0,  ADDI_W, 32'h24, 32'h0,  32'h00, 32'h00, 0, 1, 0));
        vecs.push_back(mk("haltHold2", 0, 1, 0, 32'h0,  ADDI_W, 32'h24, 32'h0,  32'h00, 32'h00, 0, 1, 0));
        vecs.push_back(mk("redir80",   0, 1, 1, 32'h80, ADDI_W, 32'h80, 32'h0,  32'h00, 32'h00, 0, 0, 1));
        vecs.push_back(mk("fetch80",   1, 1, 0, 32'h0,  ADDI_W, 32'h84, ADDI_W, 32'h80, 32'h84, 1, 0, 1));

        nRST = 1'b0; ihit = 1'b0; WEN = 1'b1; redirect = 1'b0;
        redirect_pc = '0; imemload = '0;
        #12;
        checkOutput("rst_addr",   imemaddr,   32'h0);
        checkOutput("rst_ren",    {31'b0, imemREN},    32'h1);
        checkOutput("rst_valid",  {31'b0, valid_out},  32'h0);
        checkOutput("rst_halted", {31'b0, halted_out}, 32'h0);
        checkOutput("rst_instr",  instr_out,  32'h0);
        checkOutput("rst_addr_wrap", imemaddr2, 32'hFFFFFFFC);
        @(negedge CLK);
        nRST = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput({vecs[i].name, ".addr"},   imemaddr,  vecs[i].addr);
            checkOutput({vecs[i].name, ".instr"},  instr_out, vecs[i].instr);
            checkOutput({vecs[i].name, ".pc"},     pc_out,    vecs[i].pc);
            checkOutput({vecs[i].name, ".pcn"},    pcn_out,   vecs[i].pcn);
            checkOutput({vecs[i].name, ".valid"},  {31'b0, valid_out},  {31'b0, vecs[i].valid});
            checkOutput({vecs[i].name, ".halted"}, {31'b0, halted_out}, {31'b0, vecs[i].halted});
            checkOutput({vecs[i].name, ".ren"},    {31'b0, imemREN},    {31'b0, vecs[i].ren});
            if (i == 0) begin
                checkOutput("wrap.addr", imemaddr2, 32'h0);
                checkOutput("wrap.pc",   pc_out2,   32'hFFFFFFFC);
                checkOutput("wrap.pcn",  pcn_out2,  32'h0);
            end
        end

`ifdef FETCH_PERF_EN
        checkOutput("perf.fetch_cnt", fetch_cnt, 32'd7);
        checkOutput("perf.stall_cnt", stall_cnt, 32'd5);
`endif

        // Asynchronous reset mid-cycle while a redirect is asserted: reset wins immediately.
        @(negedge CLK);
        redirect = 1'b1; redirect_pc = 32'h100; ihit = 1'b1;
        #1;
        nRST = 1'b0;
        #1;
        checkOutput("async.addr",  imemaddr, 32'h0);
        checkOutput("async.valid", {31'b0, valid_out}, 32'h0);
        checkOutput("async.pcn",   pcn_out, 32'h0);
        @(posedge CLK);
        #1;
        checkOutput("async.hold_addr", imemaddr, 32'h0);
`ifdef FETCH_PERF_EN
        checkOutput("async.fetch_cnt", fetch_cnt, 32'd0);
`endif
        redirect = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        applyStimulus(mk("postrst", 1, 1, 0, 32'h0, LW_W, 32'h04, LW_W, 32'h00, 32'h04, 1, 0, 1));
        checkOutput("postrst.addr",  imemaddr, 32'h04);
        checkOutput("postrst.instr", instr_out, LW_W);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage plus IF/ID pipeline latch for the 5-stage MIPS pipeline. Owns the PC, issues instruction-memory reads, applies branch/jump redirects and hazard stalls, and presents the fetched instruction with PC and PC+4 to decode, whose outputs load the ID/EX latch. After fetching HALT it stops fetching until a redirect squashes the halt.

## Interface
- PC_INIT, 32'h00000000, PC value loaded on reset
- CLK  in  1  clock, rising edge
- nRST  in  1  reset, asynchronous, active-low
- ihit  in  1  imem read data valid this cycle
- imemload  in  32  instruction word from imem
- imemREN  out  1  imem read request
- imemaddr  out  32  imem address (= PC)
- WEN  in  1  hazard unit: 1 = advance, 0 = stall PC and IF/ID
- redirect  in  1  taken branch/jump resolved downstream
- redirect_pc  in  32  redirect target
- instr_out  out  32  IF/ID instruction
- pc_out  out  32  IF/ID PC of instruction
- pcn_out  out  32  IF/ID PC+4, feeds ID/EX pcn
- valid_out  out  1  IF/ID holds a real instruction (0 = bubble)
- halted_out  out  1  state is HALT_SEEN
- fetch_cnt, stall_cnt  out  32 each  present only with FETCH_PERF_EN

## Operation
- State register: RUN, HALT_SEEN. Reset -> RUN.
- imemREN = (state == RUN); imemaddr = PC always.
- Priority per cycle, highest first:
  1. redirect: PC <= redirect_pc; IF/ID <= bubble; state <= RUN. Applies regardless of WEN, ihit, state.
  2. WEN = 0: PC, IF/ID, state hold.
  3. state RUN, ihit = 1: IF/ID <= {imemload, PC, PC+4, valid 1}; PC <= PC+4; if imemload[31:26] == HALT opcode, state <= HALT_SEEN.
  4. state RUN, ihit = 0: IF/ID <= bubble; PC holds.
  5. state HALT_SEEN: IF/ID <= bubble; PC holds.
- Bubble = instr 0 (sll r0 nop), pc 0, pcn 0, valid 0.
- PC+4 wraps modulo 2^32 (32'hFFFFFFFC -> 0); no exception.
- redirect_pc used as given; low two bits not checked.
- HALT is passed to decode (valid 1) in the cycle it is latched; later halt handling is downstream.

## Timing
- Reset (async): PC = PC_INIT, IF/ID = bubble, state RUN, counters 0; imemREN = 1 the first cycle after release.
- Fetch latency: instruction on imemload with ihit at edge N appears on instr_out after edge N.
- Redirect at edge N: imemaddr = redirect_pc after edge N; instruction in flight that cycle is discarded.
- Redirect coincident with ihit + HALT opcode: redirect wins, state RUN, HALT not latched.
- Redirect during reset: ignored; reset dominates.
- WEN = 0 with ihit = 1: data dropped; same address re-requested next cycle (imem must re-return it).
- All outputs registered except imemREN/imemaddr (from registered state/PC).

## Configuration
- FETCH_PERF_EN defined: fetch_cnt increments on every case-3 load; stall_cnt increments on every cycle with state RUN and (WEN = 0 or ihit = 0) and no redirect; both wrap at 2^32, clear on reset only.
- Undefined: counters and both ports absent; functionality otherwise identical.

## Structure
- cpu_types_pkg: word_t, opcode_t with HALT, add PC_STEP = 4 and fetch_state_t {RUN, HALT_SEEN}.
- Add pipereg_if_id interface (modports for stage and decode) to pipereg_if.vh.
- One sub-module: pc_reg (PC register with reset value, load-enable, next-PC mux). IF/ID latch and FSM stay in top.

## Test plan
- Reset, ihit = 1, imemload = 0x20010005 each cycle -> imemaddr 0, 4, 8; pc_out 0 with pcn_out 4, valid 1 one cycle after first ihit.
- ihit = 0 for 3 cycles at PC 8 -> imemaddr stays 8, valid_out 0 for 3 cycles, then instruction at 8 latched.
- WEN = 0 for 2 cycles at PC 0xC -> pc_out/instr_out frozen, imemaddr 0xC; release -> resume at 0x10.
- redirect = 1, redirect_pc = 0x40 with WEN = 0 and ihit = 1 -> imemaddr 0x40 next cycle, valid_out 0.
- Fetch 0xFC000000 (HALT) at 0x20 -> halted_out 1, imemREN 0, PC 0x24 held; later redirect to 0x80 -> RUN, fetch 0x80.
- PC_INIT = 0xFFFFFFFC, fetch once -> imemaddr 0, pcn_out 0; FETCH_PERF_EN: 3 hits, 2 misses -> fetch_cnt 3, stall_cnt 2.
